// File: rtl/usb_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its surroundings.
// The sequencer takes the slave side; the board-level logic takes the master side.
interface usb_reset_sequencer_if;
   logic       pll_locked;
   logic       rst_bttn;
   logic       soft_detach_req;
   logic       core_rst;
   logic       usb_dp_pull_en;
   logic       ready;
   logic [2:0] state_dbg;

   modport master (
      output pll_locked, rst_bttn, soft_detach_req,
      input  core_rst, usb_dp_pull_en, ready, state_dbg
   );

   modport slave (
      input  pll_locked, rst_bttn, soft_detach_req,
      output core_rst, usb_dp_pull_en, ready, state_dbg
   );
endinterface

// File: rtl/usb_reset_sequencer.sv
// Sequences USB core reset release against PLL lock, debounces the reset button and
// drives the D+ pull-up with attach delay, timed soft-detach and loss-of-lock recovery.
module usb_reset_sequencer #(
   parameter int unsigned RESET_HOLD_CYCLES   = 4800,
   parameter int unsigned ATTACH_DELAY_CYCLES = 480,
   parameter int unsigned DETACH_CYCLES       = 480000,
   parameter int unsigned DEBOUNCE_CYCLES     = 480000,
   parameter bit          BTN_ACTIVE_LOW      = 1'b1,
   parameter int unsigned CNT_W               = 24
) (
   input logic                  clk,
   input logic                  rst,
   usb_reset_sequencer_if.slave ctrl_io
);

   localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] AttachLast = CNT_W'(ATTACH_DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] DetachLast = CNT_W'(DETACH_CYCLES - 1);
   localparam logic [CNT_W-1:0] DbLast     = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      StWaitLock  = 3'd0,
      StHoldRst   = 3'd1,
      StAttachDly = 3'd2,
      StRun       = 3'd3,
      StDetach    = 3'd4
   } state_e;

   logic [1:0]       lock_sync_q, btn_sync_q;
   logic             lock_s, btn_s;
   logic             db_q, db_d, press_q, press_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             cause_q, core_rst_q, pull_q, ready_q;

   // Button is polarity-corrected before synchronising so 1 always means pressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_sync_q <= 2'b00;
         btn_sync_q  <= 2'b00;
      end else begin
         lock_sync_q <= {lock_sync_q[0], ctrl_io.pll_locked};
         btn_sync_q  <= {btn_sync_q[0], ctrl_io.rst_bttn ^ BTN_ACTIVE_LOW};
      end
   end

   assign lock_s = lock_sync_q[1];
   assign btn_s  = btn_sync_q[1];

   always_comb begin
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      press_d  = 1'b0;
      if (btn_s == db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DbLast) begin
         db_d     = btn_s;
         db_cnt_d = '0;
         press_d  = btn_s;
      end else begin
         db_cnt_d = db_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_q     <= 1'b0;
         db_cnt_q <= '0;
         press_q  <= 1'b0;
      end else begin
         db_q     <= db_d;
         db_cnt_q <= db_cnt_d;
         press_q  <= press_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StWaitLock;
         cnt_q      <= '0;
         cause_q    <= 1'b0;
         core_rst_q <= 1'b1;
         pull_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else if (state_q != StWaitLock && !lock_s) begin
         state_q    <= StWaitLock;
         cnt_q      <= '0;
         cause_q    <= 1'b0;
         core_rst_q <= 1'b1;
         pull_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StWaitLock: begin
               if (lock_s) begin
                  state_q <= StHoldRst;
                  cnt_q   <= '0;
               end
            end
            StHoldRst: begin
               if (press_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == HoldLast) begin
                  state_q    <= StAttachDly;
                  cnt_q      <= '0;
                  core_rst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StAttachDly: begin
               if (press_q) begin
                  state_q    <= StHoldRst;
                  cnt_q      <= '0;
                  core_rst_q <= 1'b1;
               end else if (cnt_q == AttachLast) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
                  pull_q  <= 1'b1;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StRun: begin
               // A press in the same cycle as a soft request wins.
               if (press_q || ctrl_io.soft_detach_req) begin
                  state_q    <= StDetach;
                  cnt_q      <= '0;
                  cause_q    <= press_q;
                  core_rst_q <= press_q;
                  pull_q     <= 1'b0;
                  ready_q    <= 1'b0;
               end
            end
            StDetach: begin
               if (cnt_q == DetachLast) begin
                  cnt_q <= '0;
                  if (cause_q || press_q) begin
                     state_q    <= StHoldRst;
                     core_rst_q <= 1'b1;
                  end else begin
                     state_q    <= StAttachDly;
                     core_rst_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (press_q) begin
                     cause_q    <= 1'b1;
                     core_rst_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q    <= StWaitLock;
               cnt_q      <= '0;
               cause_q    <= 1'b0;
               core_rst_q <= 1'b1;
               pull_q     <= 1'b0;
               ready_q    <= 1'b0;
            end
         endcase
      end
   end

   assign ctrl_io.core_rst       = core_rst_q;
   assign ctrl_io.usb_dp_pull_en = pull_q;
   assign ctrl_io.ready          = ready_q;
   assign ctrl_io.state_dbg      = state_q;

endmodule
